cache_assoc: RTL
================

Name: cache_assoc

Overview:
- Parametrised set-associative, write-through, write-allocate cache.
- Generalises the fixed 1 KiB 2-way data/instruction cache to configurable sets, ways, line length and replacement policy.
- Adds hit/miss statistics and a whole-cache flush.
- Sits between a hart IF or MEM stage and word-granular backing memory; one instance serves as I-cache, another as D-cache.

Parameters:
- SETS, 32, number of sets; power of 2, at least 2.
- WAYS, 2, ways per set; power of 2, 1..8.
- LINE_WORDS, 4, 32-bit words per line; power of 2, 2..16.
- REPL, 0, victim policy: 0 = NMRU, 1 = per-set round-robin.
- Derived values:
  - WO = log2(LINE_WORDS), word-offset bits.
  - S = log2(SETS), set-index bits.
  - T = 30 - WO - S, tag bits.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_mem_ready  in  1  memory can accept a request this cycle
- o_mem_addr  out  32  word-aligned memory address
- o_mem_ren  out  1  memory read request
- o_mem_wen  out  1  memory write request
- o_mem_wdata  out  32  full-word write data
- i_mem_rdata  in  32  read response data
- i_mem_valid  in  1  read response valid; responses return in order
- o_busy  out  1  stall to hart
- i_req_addr  in  32  word-aligned request address
- i_req_ren  in  1  read request
- i_req_wen  in  1  write request
- i_req_mask  in  4  byte enables for writes
- i_req_wdata  in  32  write data
- o_res_rdata  out  32  read data
- i_flush  in  1  invalidate all lines
- o_hit_count  out  32  saturating hit counter
- o_miss_count  out  32  saturating miss counter

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk.
  - All outputs 0; state IDLE.
  - All valid bits cleared; MRU and round-robin pointers 0; counters 0.
  - Reset during FILL or WRITE abandons the operation. The partially filled line stays invalid.
- Address split: tag = addr[31:32-T]; set = addr[WO+S+1:WO+2]; word = addr[WO+1:2].
- Hit: hit = OR over ways of (valid & tag match). o_res_rdata = data of the hitting way at the word offset, combinationally whenever a way hits on i_req_addr, regardless of ren; 0 on no hit.
- Memory handshake:
  - A request is accepted on a cycle where ren or wen is high and i_mem_ready is high.
  - The cache never holds ren and wen together.
  - Address and data are held stable while ready is low.
- State IDLE:
  - ren & hit: no stall; hit count +1; MRU updated at the clock edge.
  - ren & miss: o_busy=1 combinationally; miss count +1; go to FILL.
  - wen & hit: o_busy=1; line word merged per mask at the clock edge; hit count +1; go to WRITE.
  - wen & miss: o_busy=1; miss count +1; go to FILL, then WRITE.
  - ren & wen together: illegal; wen takes priority.
  - i_flush with no request: all valid bits cleared at the next edge; no stall. With a request in the same cycle, the flush is ignored.
- State FILL: o_busy=1.
  - Victim = lowest-index invalid way. Otherwise:
    - REPL=0: (MRU+1) mod WAYS.
    - REPL=1: the set's RR pointer, incremented on each fill.
  - Victim valid is cleared and its tag written on entry.
  - Reads issued to line base + 4*k, k = 0..LINE_WORDS-1, back-to-back while ready. Issue counter and response counter are separate.
  - Each i_mem_valid writes word[response counter].
  - After the last response: valid set, MRU = victim. Read request: go to IDLE, o_busy=0 the next cycle and data available by hit. Write request: go to WRITE, merging the masked write into the filled line at the transition.
- State WRITE: o_busy=1.
  - o_mem_wen=1, o_mem_addr = request address, o_mem_wdata = merged cache word.
  - On acceptance: go to IDLE, o_busy=0 the next cycle.
- Hart contract: during a stall the hart drops ren/wen but holds address, mask and wdata. The cache latches the request type on leaving IDLE.
- Counters saturate at 0xFFFFFFFF. Each request counts once; the re-check after a fill is not counted.
- WAYS=1 degenerates to direct-mapped; MRU is unused.

Decomposition:
- cache_pkg holds:
  - the state encoding (IDLE, FILL, WRITE);
  - REPL_NMRU and REPL_RR constants;
  - a function deriving T from SETS and LINE_WORDS.
- Sub-module cache_victim_sel (parametrised by WAYS and REPL): takes per-set valid vector, MRU and RR pointer; outputs victim index. It is combinational and holds no state.

Test Plan:
- Cold read to 0x0000_0100, ready always high, valid one cycle after each request:
  - 4 reads issued to 0x100, 0x104, 0x108, 0x10C; o_busy high 6 cycles.
  - Re-read returns the memory word; miss=1, hit=1.
- Write miss to 0x200, mask 4'b0011, wdata 0xAABBCCDD, memory word 0x11223344:
  - Fill completes, then o_mem_wdata = 0x1122CCDD at 0x200.
  - Subsequent read returns 0x1122CCDD.
- NMRU with 2 ways: fill tags A, B in set 3, read A, then miss on tag C. B is evicted; A still hits, B misses.
- REPL=1, 4 ways: five distinct tags into one set. The fifth evicts way 0, a sixth evicts way 1.
- i_ready held low 5 cycles mid-fill: address held; no duplicate requests; line valid only after the 4th response.
- i_rst asserted during FILL: all outputs 0 next cycle; the same address misses afterwards. Separately, i_flush in IDLE: the previously hitting address misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_WRITE
   } state_t;

   localparam int REPL_NMRU = 0;
   localparam int REPL_RR   = 1;

   // Tag width left over from a 32-bit word address once the word offset
   // and set index are removed.
   function automatic int tag_bits(input int sets, input int line_words);
      return 30 - $clog2(line_words) - $clog2(sets);
   endfunction

   // Index width that stays at least one bit for single-entry vectors.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  mask);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++)
         if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
      return res;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Word-granular backing-memory bus between the cache and memory.
// Latency: read responses return in order, any number of cycles later.
// Backpressure: a request is taken only on a cycle with ready high; the
//   master holds addr/wdata stable while ready is low.
// Signals: addr/ren/wen/wdata (request), ready (accept), rdata/rvalid (response).
interface cache_assoc_if;
   logic [31:0] addr;
   logic        ren;
   logic        wen;
   logic [31:0] wdata;
   logic        ready;
   logic [31:0] rdata;
   logic        rvalid;

   modport master (output addr, ren, wen, wdata, input ready, rdata, rvalid);
   modport slave  (input addr, ren, wen, wdata, output ready, rdata, rvalid);
endinterface

// File: rtl/cache_victim_sel.sv
// Picks the way to replace in one set: lowest invalid way, else NMRU or RR.
// Latency: combinational, no state.
// Backpressure: n/a.
// Ports: valid (per-way valid bits), mru, rr (set pointers) -> victim.
module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int WAYS = 2,
   parameter int REPL = REPL_NMRU
) (
   input  logic [WAYS-1:0]            valid,
   input  logic [idx_bits(WAYS)-1:0]  mru,
   input  logic [idx_bits(WAYS)-1:0]  rr,
   output logic [idx_bits(WAYS)-1:0]  victim
);
   localparam int WW = idx_bits(WAYS);

   always_comb begin
      // WAYS is a power of two, so the WW-bit add wraps mod WAYS.
      if (REPL == REPL_RR) victim = rr;
      else                 victim = mru + WW'(1);
      if (WAYS == 1) victim = '0;
      // Descending scan so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[w]) victim = WW'(w);
   end
endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-through, write-allocate cache with hit/miss counters.
// Latency: read hit 0 cycles; read miss stalls 1 + fill; writes stall through
//   the memory write (plus a fill on a miss).
// Backpressure: o_busy stalls the hart; memory requests wait on mem.ready.
// Ports: i_clk/i_rst, mem (master side of the memory bus), i_req_* (hart
//   request), o_res_rdata, o_busy, i_flush, o_hit_count/o_miss_count.
module cache_assoc
   import cache_pkg::*;
#(
   parameter int SETS       = 32,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4,
   parameter int REPL       = REPL_NMRU
) (
   input  logic                i_clk,
   input  logic                i_rst,
   cache_assoc_if.master       mem,
   output logic                o_busy,
   input  logic [31:0]         i_req_addr,
   input  logic                i_req_ren,
   input  logic                i_req_wen,
   input  logic [3:0]          i_req_mask,
   input  logic [31:0]         i_req_wdata,
   output logic [31:0]         o_res_rdata,
   input  logic                i_flush,
   output logic [31:0]         o_hit_count,
   output logic [31:0]         o_miss_count
);
   localparam int WO = $clog2(LINE_WORDS);
   localparam int S  = $clog2(SETS);
   localparam int T  = tag_bits(SETS, LINE_WORDS);
   localparam int WW = idx_bits(WAYS);
   localparam int CW = WO + 1;

   logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
   logic [T-1:0]    tag_q   [WAYS][SETS];
   logic [WAYS-1:0] valid_q [SETS];
   logic [WW-1:0]   mru_q   [SETS];
   logic [WW-1:0]   rr_q    [SETS];

   state_t          state_q, state_d;
   logic            write_q;
   logic [WW-1:0]   victim_q;
   logic [CW-1:0]   issue_cnt_q, resp_cnt_q;
   logic [31:0]     hit_cnt_q, miss_cnt_q;

   logic [T-1:0]    req_tag;
   logic [S-1:0]    req_set;
   logic [WO-1:0]   req_word;
   logic            hit;
   logic [WW-1:0]   hit_way;
   logic [31:0]     hit_data;
   logic [WW-1:0]   victim;
   logic            fill_done;
   logic [31:0]     fill_word;
   logic            unused_addr_bits;

   assign req_tag  = i_req_addr[31:32-T];
   assign req_set  = i_req_addr[WO+S+1:WO+2];
   assign req_word = i_req_addr[WO+1:2];
   assign unused_addr_bits = ^i_req_addr[1:0];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++)
         if (valid_q[req_set][w] && tag_q[w][req_set] == req_tag) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
   end

   assign hit_data     = hit ? data_q[hit_way][req_set][req_word] : 32'd0;
   assign o_res_rdata  = hit_data;
   assign o_hit_count  = hit_cnt_q;
   assign o_miss_count = miss_cnt_q;

   cache_victim_sel #(.WAYS(WAYS), .REPL(REPL)) u_victim (
      .valid  (valid_q[req_set]),
      .mru    (mru_q[req_set]),
      .rr     (rr_q[req_set]),
      .victim (victim)
   );

   assign fill_done = mem.rvalid && (resp_cnt_q == CW'(LINE_WORDS - 1));
   // The last response may land on the word being written, so merge onto
   // the incoming data rather than the stale array entry in that case.
   assign fill_word = (resp_cnt_q[WO-1:0] == req_word) ? mem.rdata
                                                       : data_q[victim_q][req_set][req_word];

   always_comb begin
      state_d   = state_q;
      o_busy    = 1'b0;
      mem.addr  = 32'd0;
      mem.ren   = 1'b0;
      mem.wen   = 1'b0;
      mem.wdata = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (i_req_wen) begin
               o_busy  = 1'b1;
               state_d = hit ? ST_WRITE : ST_FILL;
            end else if (i_req_ren && !hit) begin
               o_busy  = 1'b1;
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            o_busy   = 1'b1;
            mem.ren  = (issue_cnt_q != CW'(LINE_WORDS));
            mem.addr = {i_req_addr[31:WO+2], issue_cnt_q[WO-1:0], 2'b00};
            if (fill_done) state_d = write_q ? ST_WRITE : ST_IDLE;
         end
         ST_WRITE: begin
            o_busy    = 1'b1;
            mem.wen   = 1'b1;
            mem.addr  = {i_req_addr[31:2], 2'b00};
            mem.wdata = hit_data;  // line already holds the merged word
            if (mem.ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         write_q     <= 1'b0;
         victim_q    <= '0;
         issue_cnt_q <= '0;
         resp_cnt_q  <= '0;
         hit_cnt_q   <= 32'd0;
         miss_cnt_q  <= 32'd0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            mru_q[s]   <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (i_req_wen || i_req_ren) begin
                  if (hit) begin
                     hit_cnt_q <= sat_inc(hit_cnt_q);
                     if (!i_req_wen) mru_q[req_set] <= hit_way;
                  end else begin
                     miss_cnt_q                <= sat_inc(miss_cnt_q);
                     write_q                   <= i_req_wen;
                     victim_q                  <= victim;
                     valid_q[req_set][victim]  <= 1'b0;
                     rr_q[req_set]             <= rr_q[req_set] + WW'(1);
                     issue_cnt_q               <= '0;
                     resp_cnt_q                <= '0;
                  end
               end else if (i_flush) begin
                  for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
               end
            end
            ST_FILL: begin
               if (mem.ren && mem.ready) issue_cnt_q <= issue_cnt_q + CW'(1);
               if (mem.rvalid) begin
                  resp_cnt_q <= resp_cnt_q + CW'(1);
                  if (fill_done) begin
                     valid_q[req_set][victim_q] <= 1'b1;
                     mru_q[req_set]             <= victim_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Line storage carries no reset; validity alone decides what is usable.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (state_q == ST_IDLE && i_req_wen && hit)
            data_q[hit_way][req_set][req_word] <= merge_bytes(hit_data, i_req_wdata, i_req_mask);
         if (state_q == ST_IDLE && (i_req_wen || i_req_ren) && !hit)
            tag_q[victim][req_set] <= req_tag;
         if (state_q == ST_FILL && mem.rvalid) begin
            data_q[victim_q][req_set][resp_cnt_q[WO-1:0]] <= mem.rdata;
            if (fill_done && write_q)
               data_q[victim_q][req_set][req_word] <= merge_bytes(fill_word, i_req_wdata, i_req_mask);
         end
      end
   end

endmodule
